// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD add sequencer: drives one shared single-digit BCD adder LSD first and collects the result.
// Optional BCD_DIGIT_CHECK_EN adds a sticky invalid-digit flag reported on err.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err,
  output logic [3:0]          add_a,
  output logic [3:0]          add_b,
  output logic                add_cin,
  input  logic [3:0]          add_sum,
  input  logic                add_cout
);

  // state | meaning
  // IDLE  | waiting for start, add_* held at 0
  // RUN   | one digit per clock through the external adder
  // DONE  | one-cycle done pulse, result registers updated
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  opa, opb, res, res_nxt;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          last;

  assign last    = (state == RUN) && (cnt == LAST);
  // Concatenate then shift so a single-digit build needs no empty slice.
  assign res_nxt = W'({add_sum, res} >> 4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    add_a     = 4'd0;
    add_b     = 4'd0;
    add_cin   = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy    = 1'b1;
        add_a   = opa[3:0];
        add_b   = opb[3:0];
        add_cin = carry;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          opa   <= a;
          opb   <= b;
          carry <= cin;
          cnt   <= '0;
          res   <= '0;
        end
        RUN: begin
          res   <= res_nxt;
          carry <= add_cout;
          opa   <= opa >> 4;
          opb   <= opb >> 4;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum  <= res_nxt;
            cout <= add_cout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic flag;
  logic dig_bad;

  assign dig_bad = (state == RUN) && ((opa[3:0] > 4'd9) || (opb[3:0] > 4'd9));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (state == IDLE && start) flag <= 1'b0;
      else if (dig_bad)           flag <= 1'b1;
      if (last) err <= flag | dig_bad;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
